mips_cpu_mem_arbiter: RTL and testbench

MIPS_CPU_MEM_ARBITER -- requirements
Module: mips_cpu_mem_arbiter

---
 rtl/mips_cpu_mem_arbiter_if.sv | 38 +++
 rtl/mips_cpu_mem_arbiter.sv | 108 ++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_mem_arbiter_if.sv
// rtl/mips_cpu_mem_arbiter_if.sv - fetch, data and unified-memory bus bundle for the arbiter
// slave: arbiter view; master: CPU-and-memory view.
interface mips_cpu_mem_arbiter_if;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_waitrequest;

   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic [31:0] d_readdata;
   logic        d_waitrequest;

   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic [31:0] m_readdata;
   logic        m_waitrequest;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteenable,
             m_readdata, m_waitrequest,
      output i_readdata, i_waitrequest, d_readdata, d_waitrequest,
             m_address, m_read, m_write, m_writedata, m_byteenable
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteenable,
             m_readdata, m_waitrequest,
      input  i_readdata, i_waitrequest, d_readdata, d_waitrequest,
             m_address, m_read, m_write, m_writedata, m_byteenable
   );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// rtl/mips_cpu_mem_arbiter.sv - fetch/data arbiter onto one memory port, data priority with starvation limit
// Optional MIPS_CPU_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of data priority.
module mips_cpu_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic                   clk,
   input logic                   rst,
   mips_cpu_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_rd;
   logic        r_wr;

   logic w_ireq;
   logic w_dreq;
   logic w_done;
   logic w_i_done;
   logic w_d_done;
   logic w_pick_i;

   assign w_ireq   = bus.i_read;
   assign w_dreq   = bus.d_read | bus.d_write;
   assign w_done   = (r_state != IDLE) & ~bus.m_waitrequest;
   assign w_i_done = (r_state == GNT_I) & w_done;
   assign w_d_done = (r_state == GNT_D) & w_done;

`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
   logic r_last_d;

   assign w_pick_i = w_ireq & (~w_dreq | r_last_d);

   always_ff @(posedge clk) begin
      if (rst)
         r_last_d <= 1'b1;
      else if (r_state == IDLE && (w_ireq | w_dreq))
         r_last_d <= ~w_pick_i;
   end
`else
   localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
   logic [SW-1:0] r_streak;

   // Fetch wins a contended IDLE decision only once data has used up its streak.
   assign w_pick_i = w_ireq & (~w_dreq | (r_streak == SW'(STARVE_LIMIT)));

   always_ff @(posedge clk) begin
      if (rst || !w_ireq || w_i_done)
         r_streak <= '0;
      else if (w_d_done && (r_streak < SW'(STARVE_LIMIT)))
         r_streak <= r_streak + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_be    <= 4'h0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_i) begin
                  r_state <= GNT_I;
                  r_addr  <= bus.i_address;
                  r_wdata <= 32'h0;
                  r_be    <= 4'hF;
                  r_rd    <= 1'b1;
                  r_wr    <= 1'b0;
               end else if (w_dreq) begin
                  // A simultaneous read+write request is carried out as the write.
                  r_state <= GNT_D;
                  r_addr  <= bus.d_address;
                  r_wdata <= bus.d_write ? bus.d_writedata : 32'h0;
                  r_be    <= bus.d_write ? bus.d_byteenable : 4'hF;
                  r_rd    <= ~bus.d_write;
                  r_wr    <= bus.d_write;
               end
            end
            default: begin
               if (!bus.m_waitrequest) begin
                  r_state <= IDLE;
                  r_be    <= 4'h0;
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.m_address     = r_addr;
   assign bus.m_writedata   = r_wdata;
   assign bus.m_byteenable  = r_be;
   assign bus.m_read        = r_rd;
   assign bus.m_write       = r_wr;

   assign bus.i_waitrequest = w_ireq & ~w_i_done;
   assign bus.d_waitrequest = w_dreq & ~w_d_done;
   assign bus.i_readdata    = w_i_done ? bus.m_readdata : 32'h0;
   assign bus.d_readdata    = w_d_done ? bus.m_readdata : 32'h0;
endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb/tb_mips_cpu_mem_arbiter.sv - self-checking bench for mips_cpu_mem_arbiter
// Honours MIPS_CPU_ARB_ROUND_ROBIN_EN in its expected grant order.
module tb_mips_cpu_mem_arbiter;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   mips_cpu_mem_arbiter_if bus();

   mips_cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.m_readdata = mem[bus.m_address[5:2]];

   task automatic idle_inputs();
      bus.i_read        = 1'b0;
      bus.i_address     = 32'h0;
      bus.d_read        = 1'b0;
      bus.d_write       = 1'b0;
      bus.d_address     = 32'h0;
      bus.d_writedata   = 32'h0;
      bus.d_byteenable  = 4'h0;
      bus.m_waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic settle();
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable, bus.m_writedata} !== 70'h0) begin
         errors++;
         $display("FAIL reset_mbus: got rd=%b wr=%b a=%h be=%h wd=%h expected all zero",
                  bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable, bus.m_writedata);
      end
      checks++;
      if ({bus.i_waitrequest, bus.d_waitrequest} !== 2'b11) begin
         errors++;
         $display("FAIL reset_wait: got iw=%b dw=%b expected 1 1", bus.i_waitrequest, bus.d_waitrequest);
      end
      checks++;
      if ({bus.i_readdata, bus.d_readdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h %h expected 0 0", bus.i_readdata, bus.d_readdata);
      end
      @(posedge clk);
      #1 idle_inputs();
      rst = 1'b0;
   endtask

   task automatic test_boot_fetch();
      do_reset();
      bus.i_read    = 1'b1;
      bus.i_address = 32'hBFC00000;
      @(negedge clk);
      checks++;
      if ({bus.m_read, bus.i_waitrequest} !== 2'b01) begin
         errors++;
         $display("FAIL fetch_idle: got m_read=%b iw=%b expected 0 1", bus.m_read, bus.i_waitrequest);
      end
      @(negedge clk);
      checks++;
      if ({bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable} !== {2'b10, 32'hBFC00000, 4'hF}) begin
         errors++;
         $display("FAIL fetch_grant: got rd=%b wr=%b a=%h be=%h expected 1 0 bfc00000 f",
                  bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable);
      end
      checks++;
      if ({bus.i_waitrequest, bus.i_readdata} !== {1'b0, mem[0]}) begin
         errors++;
         $display("FAIL fetch_done: got iw=%b rd=%h expected 0 %h", bus.i_waitrequest, bus.i_readdata, mem[0]);
      end
      @(posedge clk);
      #1 bus.i_read = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.m_read !== 1'b0) begin
         errors++;
         $display("FAIL fetch_return_idle: got m_read=%b expected 0", bus.m_read);
      end
   endtask

   task automatic test_write_stall();
      settle();
      bus.d_write       = 1'b1;
      bus.d_address     = 32'h1000;
      bus.d_writedata   = 32'hDEADBEEF;
      bus.d_byteenable  = 4'b0011;
      bus.m_waitrequest = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1 bus.m_waitrequest = (k != 4);
         @(negedge clk);
         checks++;
         if ({bus.m_write, bus.m_read, bus.m_address, bus.m_writedata, bus.m_byteenable, bus.d_waitrequest}
             !== {2'b10, 32'h1000, 32'hDEADBEEF, 4'b0011, (k != 4)}) begin
            errors++;
            $display("FAIL write_stall_c%0d: got wr=%b rd=%b a=%h wd=%h be=%b dw=%b expected 1 0 1000 deadbeef 0011 %b",
                     k, bus.m_write, bus.m_read, bus.m_address, bus.m_writedata, bus.m_byteenable,
                     bus.d_waitrequest, (k != 4));
         end
      end
      @(posedge clk);
      #1 bus.d_write = 1'b0;
      bus.m_waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.m_write, bus.m_byteenable} !== 5'b0) begin
         errors++;
         $display("FAIL write_idle: got wr=%b be=%b expected 0 0000", bus.m_write, bus.m_byteenable);
      end
   endtask

   task automatic test_starvation();
      int  g;
      bit  exp_i;
      bit  got_i;
      do_reset();
      bus.i_read    = 1'b1;
      bus.i_address = 32'h40;
      bus.d_read    = 1'b1;
      bus.d_address = 32'h80;
      g = 0;
      for (int c = 0; c < 40 && g < 10; c++) begin
         @(negedge clk);
         if (bus.m_read === 1'b1) begin
            got_i = (bus.m_address == 32'h40);
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
            exp_i = (g % 2) == 0;
`else
            exp_i = (g % (LIMIT + 1)) == LIMIT;
`endif
            checks++;
            if (got_i !== exp_i) begin
               errors++;
               $display("FAIL starve_order_%0d: got %s expected %s", g, got_i ? "I" : "D", exp_i ? "I" : "D");
            end
            g++;
         end
      end
      checks++;
      if (g != 10) begin
         errors++;
         $display("FAIL starve_timeout: got %0d grants expected 10", g);
      end
      @(posedge clk);
      #1 idle_inputs();
   endtask

   task automatic test_rw_both();
      settle();
      bus.d_read       = 1'b1;
      bus.d_write      = 1'b1;
      bus.d_address    = 32'h20;
      bus.d_writedata  = 32'h12345678;
      bus.d_byteenable = 4'b1100;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.m_write, bus.m_read, bus.m_byteenable, bus.m_writedata} !== {2'b10, 4'b1100, 32'h12345678}) begin
         errors++;
         $display("FAIL rw_both: got wr=%b rd=%b be=%b wd=%h expected 1 0 1100 12345678",
                  bus.m_write, bus.m_read, bus.m_byteenable, bus.m_writedata);
      end
      @(posedge clk);
      #1 idle_inputs();
   endtask

   task automatic test_reset_mid_grant();
      settle();
      bus.d_read        = 1'b1;
      bus.d_address     = 32'h44;
      bus.m_waitrequest = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.m_read !== 1'b1) begin
         errors++;
         $display("FAIL midrst_grant: got m_read=%b expected 1", bus.m_read);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.m_read, bus.m_write, bus.m_address, bus.d_waitrequest} !== {2'b00, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL midrst_idle: got rd=%b wr=%b a=%h dw=%b expected 0 0 0 1",
                  bus.m_read, bus.m_write, bus.m_address, bus.d_waitrequest);
      end
      @(posedge clk);
      #1 idle_inputs();
   endtask

   // Transaction-level model: grant choice, owner completion and memory contents.
   task automatic test_random();
      int          owner;
      int          streak;
      bit          last_d;
      bit          p_ireq, p_dreq, p_act, p_done;
      int          p_streak;
      bit          ireq, dreq, mact, pred_i, pred_d, cmp_i, cmp_d, i_rel, d_rel;
      logic [31:0] own_addr, own_wdata, exp_ird, exp_drd;
      logic [3:0]  own_be;
      bit          own_wr;
      bit          exp_iw, exp_dw;
      int          kind;
      do_reset();
      owner = 0; streak = 0; last_d = 1'b1;
      p_ireq = 0; p_dreq = 0; p_act = 0; p_done = 0; p_streak = 0;
      i_rel = 0; d_rel = 0;
      own_addr = 0; own_wdata = 0; own_be = 0; own_wr = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc != 0) begin
            @(posedge clk);
            #1;
         end
         if (i_rel) bus.i_read = 1'b0;
         else if (!bus.i_read && $urandom_range(0, 2) == 0) begin
            bus.i_read    = 1'b1;
            bus.i_address = $urandom() & 32'hFFFF_FFFC;
         end
         if (d_rel) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end else if (!(bus.d_read || bus.d_write) && $urandom_range(0, 2) == 0) begin
            kind             = $urandom_range(0, 3);
            bus.d_read       = (kind != 2);
            bus.d_write      = (kind >= 2);
            bus.d_address    = $urandom() & 32'hFFFF_FFFC;
            bus.d_writedata  = $urandom();
            bus.d_byteenable = 4'($urandom_range(0, 15));
         end
         bus.m_waitrequest = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         ireq = bus.i_read;
         dreq = bus.d_read | bus.d_write;
         mact = bus.m_read | bus.m_write;
         if (p_act) begin
            checks++;
            if (mact !== !p_done) begin
               errors++;
               $display("FAIL rand_continuity cyc %0d: got active=%b expected %b", cyc, mact, !p_done);
            end
         end
         if (mact && !p_act) begin
`ifdef MIPS_CPU_ARB_ROUND_ROBIN_EN
            pred_i = p_ireq && (!p_dreq || last_d);
`else
            pred_i = p_ireq && (!p_dreq || p_streak == LIMIT);
`endif
            pred_d = !pred_i && p_dreq;
            last_d = pred_d;
            if (pred_i) begin
               owner = 1; own_addr = bus.i_address; own_wr = 0; own_be = 4'hF; own_wdata = 0;
            end else if (pred_d) begin
               owner = 2; own_addr = bus.d_address; own_wr = bus.d_write;
               own_be = bus.d_write ? bus.d_byteenable : 4'hF;
               own_wdata = bus.d_write ? bus.d_writedata : 32'h0;
            end else owner = 0;
            checks++;
            if (owner == 0 || {bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable} !==
                              {!own_wr, own_wr, own_addr, own_be} ||
                (own_wr && bus.m_writedata !== own_wdata)) begin
               errors++;
               $display("FAIL rand_grant cyc %0d: got rd=%b wr=%b a=%h be=%h expected owner %0d rd=%b wr=%b a=%h be=%h",
                        cyc, bus.m_read, bus.m_write, bus.m_address, bus.m_byteenable,
                        owner, !own_wr, own_wr, own_addr, own_be);
            end
         end
         cmp_i   = mact && owner == 1 && !bus.m_waitrequest;
         cmp_d   = mact && owner == 2 && !bus.m_waitrequest;
         exp_iw  = ireq && !cmp_i;
         exp_dw  = dreq && !cmp_d;
         exp_ird = cmp_i ? mem[own_addr[5:2]] : 32'h0;
         exp_drd = cmp_d ? mem[own_addr[5:2]] : 32'h0;
         checks++;
         if ({bus.i_waitrequest, bus.d_waitrequest, bus.i_readdata, bus.d_readdata} !==
             {exp_iw, exp_dw, exp_ird, exp_drd}) begin
            errors++;
            $display("FAIL rand_resp cyc %0d: got iw=%b dw=%b ird=%h drd=%h expected %b %b %h %h",
                     cyc, bus.i_waitrequest, bus.d_waitrequest, bus.i_readdata, bus.d_readdata,
                     exp_iw, exp_dw, exp_ird, exp_drd);
         end
         if (cmp_d && own_wr)
            for (int b = 0; b < 4; b++)
               if (own_be[b]) mem[own_addr[5:2]][8*b +: 8] = own_wdata[8*b +: 8];
         p_ireq   = ireq;
         p_dreq   = dreq;
         p_streak = streak;
         if (!ireq || cmp_i) streak = 0;
         else if (cmp_d && streak < LIMIT) streak++;
         p_act  = mact;
         p_done = cmp_i | cmp_d;
         i_rel  = cmp_i;
         d_rel  = cmp_d;
      end
      @(posedge clk);
      #1 idle_inputs();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = $urandom();
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_boot_fetch();
      test_write_stall();
      test_starvation();
      test_rw_both();
      test_reset_mid_grant();
      test_random();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
